risc_seq_fsm: RTL

Moore-style controller that sequences the Simple RISC Machine datapath for one instruction at a time. It takes opcode/op from the instruction decoder and a start strobe from the top level. It drives the decoder's one-hot register select (nsel) and every datapath load, select and write enable. It sits between the instruction register/decoder and the register-file/ALU datapath.

---
 rtl/risc_seq_fsm.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/risc_seq_fsm.sv
// risc_seq_fsm -- Moore controller that steps the Simple RISC Machine datapath
// through one instruction at a time.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (state -> S_WAIT at once)
//   s        in   start strobe, honoured only in S_WAIT
//   opcode   in   [2:0] IR[15:13] from the decoder
//   op       in   [1:0] IR[12:11] from the decoder
//   w        out  1 while idle and ready to accept s
//   nsel     out  [2:0] one-hot register select: 100=Rn, 010=Rd, 001=Rm
//   loada/loadb/loadc/loads  out  datapath register / status loads
//   asel     out  1 forces ALU A input to zero
//   bsel     out  1 selects sximm5 for ALU B, 0 selects the shifter
//   vsel     out  [1:0] writeback source: 00=C, 10=sximm8
//   write    out  register-file write enable
//   err      out  illegal-instruction indication
//
// Optional feature macro: SEQ_ILLEGAL_TRAP_EN
//   defined   : illegal {opcode,op} parks the FSM in S_HALT (err=1) until reset
//   undefined : illegal {opcode,op} is a one-cycle NOP, err tied to 0

module risc_seq_fsm #(
    parameter int unsigned STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       err
);

    typedef enum logic [STATE_W-1:0] {
        S_WAIT,
        S_DECODE,
        S_WIMM,
        S_GETA,
        S_GETB,
        S_MOVSH,
        S_ALU,
        S_CMP,
        S_WREG,
        S_HALT
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore outputs; everything defaults to inactive.
    always_comb begin
        state_d = state_q;
        w       = 1'b0;
        nsel    = 3'b000;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        vsel    = 2'b00;
        write   = 1'b0;
        err     = 1'b0;

        unique case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if ({opcode, op} == 5'b110_10) begin
                    state_d = S_WIMM;
                end else if ({opcode, op} == 5'b110_00) begin
                    state_d = S_GETB;
                end else if (opcode == 3'b101) begin
                    state_d = S_GETA;
                end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_WAIT;
`endif
                end
            end
            S_WIMM: begin
                nsel    = 3'b100;
                vsel    = 2'b10;
                write   = 1'b1;
                state_d = S_WAIT;
            end
            S_GETA: begin
                nsel    = 3'b100;
                loada   = 1'b1;
                state_d = S_GETB;
            end
            S_GETB: begin
                nsel  = 3'b001;
                loadb = 1'b1;
                // Second decode point: the IR is stable while w=0.
                if (opcode == 3'b110) begin
                    state_d = S_MOVSH;
                end else if (op == 2'b01) begin
                    state_d = S_CMP;
                end else begin
                    state_d = S_ALU;
                end
            end
            S_MOVSH: begin
                // ALUop is 00 for MOV, so C = 0 + shifted Rm.
                asel    = 1'b1;
                loadc   = 1'b1;
                state_d = S_WREG;
            end
            S_ALU: begin
                loadc   = 1'b1;
                state_d = S_WREG;
            end
            S_CMP: begin
                loads   = 1'b1;
                state_d = S_WAIT;
            end
            S_WREG: begin
                nsel    = 3'b010;
                write   = 1'b1;
                state_d = S_WAIT;
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            S_HALT: begin
                err     = 1'b1;
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

endmodule
